// File: rtl/ts_msg_sequencer.sv
// ts_msg_sequencer
// Turns one captured timestamp event into the ASCII line
//   <chan hex> ':' <TS_WIDTH/4 hex digits, MSB first> CR LF
// and feeds it byte by byte to the utx UART transmitter. Each byte gets one
// tx_load pulse. The next byte is loaded only after utx reports tx_done.
module ts_msg_sequencer #(
  parameter int TS_WIDTH   = 32,
  parameter int CHAN_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  ts_valid,
  input  logic [CHAN_WIDTH-1:0] ts_chan,
  input  logic [TS_WIDTH-1:0]   ts_value,
  output logic                  ts_ready,
  output logic                  tx_load,
  output logic [7:0]            tx_byte,
  input  logic                  tx_done,
  output logic                  busy,
  output logic [7:0]            drop_cnt
);

  localparam int NIBBLES = TS_WIDTH / 4;
  localparam int LAST    = NIBBLES + 3;
  localparam int IDX_W   = $clog2(LAST + 1);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LAST);
  localparam logic [IDX_W-1:0] CR_IDX    = IDX_W'(LAST - 1);
  localparam logic [IDX_W-1:0] COLON_IDX = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT
  } state_e;

  state_e                state_q,    state_d;
  logic [CHAN_WIDTH-1:0] chan_q,     chan_d;
  logic [TS_WIDTH-1:0]   value_q,    value_d;
  logic [IDX_W-1:0]      idx_q,      idx_d;
  logic [7:0]            tx_byte_q,  tx_byte_d;
  logic [7:0]            drop_cnt_q, drop_cnt_d;

  // Convert one nibble to an uppercase ASCII hex digit.
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Return the message byte at position idx for the given event.
  function automatic logic [7:0] msg_byte(input logic [IDX_W-1:0]      idx,
                                          input logic [CHAN_WIDTH-1:0] chan,
                                          input logic [TS_WIDTH-1:0]   value);
    logic [3:0] chan4;
    logic [3:0] nib;
    chan4                   = '0;
    chan4[CHAN_WIDTH-1:0]   = chan;
    nib                     = '0;
    for (int k = 0; k < NIBBLES; k++) begin
      if (int'(idx) == k + 2) nib = value[TS_WIDTH-1-4*k -: 4];
    end
    if (idx == '0)             return hex_ascii(chan4);
    else if (idx == COLON_IDX) return 8'h3A;
    else if (idx == CR_IDX)    return 8'h0D;
    else if (idx == LAST_IDX)  return 8'h0A;
    else                       return hex_ascii(nib);
  endfunction

  // Compute the next state, the capture registers, the next byte and the drop counter.
  always_comb begin
    // NOTE: every signal written here gets a default first. A path that leaves
    // one unassigned would infer a latch instead of combinational logic.
    state_d    = state_q;
    chan_d     = chan_q;
    value_d    = value_q;
    idx_d      = idx_q;
    tx_byte_d  = tx_byte_q;
    drop_cnt_d = drop_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (ts_valid) begin
          chan_d  = ts_chan;
          value_d = ts_value;
          idx_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: state_d = S_WAIT;
      S_WAIT: begin
        if (tx_done) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + IDX_ONE;
            state_d = S_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Register the byte on entry to LOAD so it is stable for the whole LOAD/WAIT span.
    if (state_d == S_LOAD) tx_byte_d = msg_byte(idx_d, chan_d, value_d);

    // An event offered while busy is lost. Count it, saturating at 8'hFF.
    if (ts_valid && (state_q != S_IDLE) && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  // Register the state, the capture registers, the index, the byte and the drop counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      chan_q     <= '0;
      value_q    <= '0;
      idx_q      <= '0;
      tx_byte_q  <= 8'h00;
      drop_cnt_q <= 8'h00;
    end else begin
      // NOTE: sequential state uses non-blocking assignments. Every flop then
      // samples the values from before the edge, whatever the statement order.
      state_q    <= state_d;
      chan_q     <= chan_d;
      value_q    <= value_d;
      idx_q      <= idx_d;
      tx_byte_q  <= tx_byte_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign ts_ready = (state_q == S_IDLE);
  assign busy     = ~ts_ready;
  assign tx_load  = (state_q == S_LOAD);
  assign tx_byte  = tx_byte_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_ts_msg_sequencer.sv
// Testbench for ts_msg_sequencer.
// A reference model builds the expected ASCII line with string formatting and
// predicts the drop counter. The bench emulates utx by pulsing tx_done after a
// random delay following each tx_load.
`timescale 1ns/1ps
module tb_ts_msg_sequencer;

  localparam int TS_WIDTH   = 32;
  localparam int CHAN_WIDTH = 2;
  localparam int LAST       = TS_WIDTH / 4 + 3;

  logic                  clk      = 1'b0;
  logic                  rstn     = 1'b0;
  logic                  ts_valid = 1'b0;
  logic [CHAN_WIDTH-1:0] ts_chan  = '0;
  logic [TS_WIDTH-1:0]   ts_value = '0;
  logic                  tx_done  = 1'b0;
  logic                  ts_ready;
  logic                  tx_load;
  logic [7:0]            tx_byte;
  logic                  busy;
  logic [7:0]            drop_cnt;

  int         checks     = 0;
  int         failures   = 0;
  int         exp_drop   = 0;
  bit         model_busy = 1'b0;
  logic [7:0] exp_q[$];

  always #50 clk = ~clk;

  ts_msg_sequencer #(
    .TS_WIDTH  (TS_WIDTH),
    .CHAN_WIDTH(CHAN_WIDTH)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .ts_valid(ts_valid),
    .ts_chan (ts_chan),
    .ts_value(ts_value),
    .ts_ready(ts_ready),
    .tx_load (tx_load),
    .tx_byte (tx_byte),
    .tx_done (tx_done),
    .busy    (busy),
    .drop_cnt(drop_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock, from one falling edge to the next. The drop model
  // counts the rising edge if a valid event meets a busy sequencer.
  task automatic tick();
    bit drop_now;
    drop_now = ts_valid && model_busy;
    @(posedge clk);
    if (drop_now && exp_drop < 255) exp_drop++;
    @(negedge clk);
  endtask

  // Build the expected line: "<chan>:<value>" in uppercase hex, then CR LF.
  task automatic build_msg(input logic [CHAN_WIDTH-1:0] chan, input logic [TS_WIDTH-1:0] value);
    string      s;
    logic [3:0] c4;
    c4 = 4'(chan);
    s  = $sformatf("%h:%h", c4, value);
    s  = s.toupper();
    exp_q.delete();
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic check_reset_outputs();
    check("rst_ready",   {31'd0, ts_ready}, 32'd1);
    check("rst_busy",    {31'd0, busy},     32'd0);
    check("rst_load",    {31'd0, tx_load},  32'd0);
    check("rst_byte",    {24'd0, tx_byte},  32'd0);
    check("rst_drop",    {24'd0, drop_cnt}, 32'd0);
  endtask

  // Reset in the middle of a message. The bench expects everything to return
  // to its reset value at once and no further tx_load to appear.
  task automatic do_reset();
    rstn       = 1'b0;
    ts_valid   = 1'b0;
    model_busy = 1'b0;
    exp_drop   = 0;
    #1;
    check_reset_outputs();
    tick();
    rstn = 1'b1;
    repeat (5) begin
      tick();
      check("post_rst_load",  {31'd0, tx_load},  32'd0);
      check("post_rst_ready", {31'd0, ts_ready}, 32'd1);
    end
  endtask

  // The caller has ts_valid/ts_chan/ts_value driven and the next rising edge is
  // the accept edge. hold keeps ts_valid high throughout. abort_at >= 0 applies
  // reset right after that byte's load.
  task automatic run_msg(input int dmin, input int dmax, input bit hold, input int abort_at);
    int d;
    build_msg(ts_chan, ts_value);
    check("ready_before_accept", {31'd0, ts_ready}, 32'd1);
    tick();
    model_busy = 1'b1;
    if (!hold) ts_valid = 1'b0;
    ts_chan  = CHAN_WIDTH'($urandom);
    ts_value = TS_WIDTH'($urandom);
    for (int k = 0; k <= LAST; k++) begin
      check("load_pulse", {31'd0, tx_load},  32'd1);
      check("byte",       {24'd0, tx_byte},  {24'd0, exp_q[k]});
      check("busy",       {31'd0, busy},     32'd1);
      check("ready_low",  {31'd0, ts_ready}, 32'd0);
      if (k == abort_at) begin
        do_reset();
        return;
      end
      d = $urandom_range(dmax, dmin);
      repeat (d) begin
        tick();
        check("no_load",   {31'd0, tx_load}, 32'd0);
        check("byte_hold", {24'd0, tx_byte}, {24'd0, exp_q[k]});
      end
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
    end
    model_busy = 1'b0;
    check("ready_after_final", {31'd0, ts_ready}, 32'd1);
    check("load_after_final",  {31'd0, tx_load},  32'd0);
    check("drop_cnt",          {24'd0, drop_cnt}, exp_drop);
  endtask

  task automatic offer(input logic [CHAN_WIDTH-1:0] chan, input logic [TS_WIDTH-1:0] value);
    ts_valid = 1'b1;
    ts_chan  = chan;
    ts_value = value;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) tick();
    check_reset_outputs();
    rstn = 1'b1;
    tick();

    // Reference message with the utx-like 870-cycle gap after each load.
    offer(2'd2, 32'h00AB_CDEF);
    run_msg(870, 870, 1'b0, -1);

    // tx_done while idle is ignored.
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    repeat (3) begin
      tick();
      check("idle_done_load",  {31'd0, tx_load},  32'd1 - 32'd1);
      check("idle_done_ready", {31'd0, ts_ready}, 32'd1);
    end

    // All-F digits and the largest channel value, then all-zero digits.
    offer(2'd3, 32'hFFFF_FFFF);
    run_msg(1, 4, 1'b0, -1);
    tick();
    offer(2'd0, 32'h0000_0000);
    run_msg(1, 3, 1'b0, -1);

    // ts_valid held high: the drop count grows, and the next event is taken
    // back-to-back on the cycle ts_ready rises. The second message saturates
    // the drop count.
    offer(2'd1, 32'h1234_5678);
    run_msg(1, 3, 1'b1, -1);
    offer(2'd2, 32'h9ABC_DEF0);
    run_msg(20, 30, 1'b1, -1);
    ts_valid = 1'b0;
    tick();
    check("drop_saturated", {24'd0, drop_cnt}, 32'd255);

    // Reset after byte 5, then a fresh message restarting at byte 0.
    offer(2'd1, 32'hDEAD_BEEF);
    run_msg(2, 5, 1'b0, 5);
    offer(2'd3, 32'h0F1E_2D3C);
    run_msg(1, 6, 1'b0, -1);

    // Random events with random utx delays and idle gaps.
    for (int n = 0; n < 15; n++) begin
      repeat ($urandom_range(3, 0)) tick();
      offer(CHAN_WIDTH'($urandom), TS_WIDTH'($urandom));
      run_msg(1, 8, 1'b0, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
